// File: rtl/timer_ctrl.sv
// timer_ctrl: debounces the start/stop, clear and lap pads, sequences the
// IDLE/RUN/PAUSE/LAP run state, gates the prescaled count tick and the clear
// pulse into the timer counter, and scans the four seven-segment digits.
// Optional feature macro: TIMER_CTRL_LAP_EN (LAP state and hold output).
module timer_ctrl #(
    parameter int TICK_DIV     = 10000,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SCAN_DIV     = 256
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       hold,
    output logic [1:0] digit_sel,
    output logic [3:0] digit_en,
    output logic [1:0] state_o
);

`ifdef TIMER_CTRL_LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t        state;
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] acc;
    logic [NB-1:0] acc_q;
    logic [NB-1:0] press;
    logic [DW-1:0] db_cnt [NB];
    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;
    logic          ev_ss;
    logic          ev_clr;
    logic          ev_lap;

    // Button bit order: 0 = start/stop, 1 = clear, 2 = lap (when present).
`ifdef TIMER_CTRL_LAP_EN
    assign raw    = {btn_lap, btn_clear, btn_start_stop};
    assign ev_lap = press[2];
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign raw        = {btn_clear, btn_start_stop};
    assign ev_lap     = 1'b0;
    assign hold       = 1'b0;
`endif

    assign ev_ss   = press[0];
    assign ev_clr  = press[1];
    assign state_o = state;

    // Two-flop synchronizers bring the asynchronous pads into the clock domain.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing samples; register rising-edge press events.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc   <= '0;
            acc_q <= '0;
            press <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            acc_q <= acc;
            press <= acc & ~acc_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEB_MAX) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Run-state machine; clear beats start/stop beats lap, one transition per cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            cnt_clr <= 1'b0;
`ifdef TIMER_CTRL_LAP_EN
            hold    <= 1'b0;
`endif
        end else begin
            cnt_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_clr) begin
                        cnt_clr <= 1'b1;
                    end else if (ev_ss) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (ev_ss) begin
                        state <= PAUSE;
                    end else if (ev_lap) begin
                        state <= LAP;
`ifdef TIMER_CTRL_LAP_EN
                        hold  <= 1'b1;
`endif
                    end
                end
                LAP: begin
                    if (ev_ss) begin
                        state <= PAUSE;
                    end else if (ev_lap) begin
                        state <= RUN;
                    end
`ifdef TIMER_CTRL_LAP_EN
                    if (ev_ss || ev_lap) begin
                        hold <= 1'b0;
                    end
`endif
                end
                PAUSE: begin
                    if (ev_clr) begin
                        state   <= IDLE;
                        cnt_clr <= 1'b1;
                    end else if (ev_ss) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler: counts while running, holds in PAUSE, zero in IDLE; wrap gives a registered tick.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            presc  <= '0;
            cnt_en <= 1'b0;
        end else begin
            cnt_en <= 1'b0;
            if (state == RUN || state == LAP) begin
                if (presc == PRESC_MAX) begin
                    presc  <= '0;
                    cnt_en <= 1'b1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end else if (state == IDLE) begin
                presc <= '0;
            end
        end
    end

    // Digit scan: advance the selected digit every SCAN_DIV cycles, enable decoded alongside.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
            digit_en  <= 4'b0001;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 2'd1;
            digit_en  <= 4'b0001 << (digit_sel + 2'd1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl: hand sequences, a table of button presses and
// randomized pad activity, all checked against a behavioural model.
module tb_timer_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int DEBOUNCE_CYC = 3;
    localparam int SCAN_DIV     = 2;
`ifdef TIMER_CTRL_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_ss = 1'b0;
    logic       b_clr = 1'b0;
    logic       b_lap = 1'b0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       hold;
    logic [1:0] digit_sel;
    logic [3:0] digit_en;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_bad = 0;
    int clr_seen = 0;

    // Behavioural model state (values as seen just after a clock edge)
    int m_s1[3], m_s2[3], m_acc[3], m_dcnt[3], m_rise1[3], m_rise2[3];
    int m_state, m_hold, m_clr, m_en, m_phase, m_cyc;

    typedef struct {
        logic [2:0] btn;   // {lap, clear, start_stop}
        int         st;
        int         hld;
        int         clrs;
    } vec_t;

    vec_t tbl[16];

    timer_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .SCAN_DIV    (SCAN_DIV)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .btn_start_stop(b_ss),
        .btn_clear     (b_clr),
        .btn_lap       (b_lap),
        .cnt_en        (cnt_en),
        .cnt_clr       (cnt_clr),
        .hold          (hold),
        .digit_sel     (digit_sel),
        .digit_en      (digit_en),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_dcnt[b] = 0;
            m_rise1[b] = 0; m_rise2[b] = 0;
        end
        m_state = 0; m_hold = 0; m_clr = 0; m_en = 0; m_phase = 0; m_cyc = 0;
    endtask

    // One clock edge of the specified behaviour, using the pad levels at the edge.
    task automatic model_step();
        int raw[3];
        int ev[3];
        int nxt;
        raw[0] = int'(b_ss);
        raw[1] = int'(b_clr);
        raw[2] = LAP_ON ? int'(b_lap) : 0;
        for (int b = 0; b < 3; b++) begin
            // a rise of the accepted level reaches the state machine two edges later
            ev[b] = m_rise2[b];
            m_rise2[b] = m_rise1[b];
            m_rise1[b] = 0;
            // debouncer sees the level after two synchronizer stages
            if (m_s2[b] != m_acc[b]) begin
                m_dcnt[b]++;
                if (m_dcnt[b] == DEBOUNCE_CYC) begin
                    m_acc[b] = m_s2[b];
                    m_dcnt[b] = 0;
                    if (m_acc[b] == 1) m_rise1[b] = 1;
                end
            end else begin
                m_dcnt[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
        m_en = 0;
        if (m_state == 1 || m_state == 3) begin
            m_phase = (m_phase + 1) % TICK_DIV;
            m_en = (m_phase == 0) ? 1 : 0;
        end else if (m_state == 0) begin
            m_phase = 0;
        end
        m_clr = 0;
        nxt = m_state;
        case (m_state)
            0: if (ev[1] == 1) m_clr = 1; else if (ev[0] == 1) nxt = 1;
            1: if (ev[0] == 1) nxt = 2; else if (ev[2] == 1) nxt = 3;
            3: if (ev[0] == 1) nxt = 2; else if (ev[2] == 1) nxt = 1;
            2: if (ev[1] == 1) begin nxt = 0; m_clr = 1; end else if (ev[0] == 1) nxt = 1;
            default: nxt = 0;
        endcase
        m_state = nxt;
        m_hold = (nxt == 3) ? 1 : 0;
        m_cyc++;
    endtask

    task automatic check_model(string name);
        logic [10:0] act;
        logic [10:0] exp;
        logic [3:0]  een;
        int          sel;
        sel = (m_cyc / SCAN_DIV) % 4;
        een = 4'b0001 << sel;
        act = {state_o, hold, cnt_en, cnt_clr, digit_sel, digit_en};
        exp = {2'(m_state), 1'(m_hold), 1'(m_en), 1'(m_clr), 2'(sel), een};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got st=%0d hold=%b en=%b clr=%b sel=%0d den=%b, want st=%0d hold=%0d en=%0d clr=%0d sel=%0d den=%b",
                     name, m_cyc, state_o, hold, cnt_en, cnt_clr, digit_sel, digit_en,
                     m_state, m_hold, m_en, m_clr, sel, een);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(string name);
        @(posedge clk);
        model_step();
        #1;
        if (cnt_clr === 1'b1) clr_seen++;
        check_model(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({state_o, hold, cnt_en, cnt_clr, digit_sel, digit_en} !== {2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001}) begin
            n_bad++;
            $display("FAIL async_reset: got st=%0d hold=%b en=%b clr=%b sel=%0d den=%b, want st=0 hold=0 en=0 clr=0 sel=0 den=0001",
                     state_o, hold, cnt_en, cnt_clr, digit_sel, digit_en);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_btn(logic [2:0] m, int hi, int lo);
        b_ss = m[0]; b_clr = m[1]; b_lap = m[2];
        repeat (hi) step("press_hi");
        b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
        repeat (lo) step("press_lo");
    endtask

    initial begin
        int en_pos[$];
        int exp_sel[8];
        int exp_den[8];
        int n_tick;
        int found;
        int lst;
        int hold_left[3];
        logic [2:0] lvl;

        exp_sel = '{0, 1, 1, 2, 2, 3, 3, 0};
        exp_den = '{1, 2, 2, 4, 4, 8, 8, 1};
        lst = LAP_ON ? 3 : 1;
        tbl[0]  = '{3'b010, 0, 0, 1};
        tbl[1]  = '{3'b100, 0, 0, 0};
        tbl[2]  = '{3'b001, 1, 0, 0};
        tbl[3]  = '{3'b010, 1, 0, 0};
        tbl[4]  = '{3'b100, lst, int'(LAP_ON), 0};
        tbl[5]  = '{3'b010, lst, int'(LAP_ON), 0};
        tbl[6]  = '{3'b100, 1, 0, 0};
        tbl[7]  = '{3'b001, 2, 0, 0};
        tbl[8]  = '{3'b100, 2, 0, 0};
        tbl[9]  = '{3'b011, 0, 0, 1};
        tbl[10] = '{3'b001, 1, 0, 0};
        tbl[11] = '{3'b100, lst, int'(LAP_ON), 0};
        tbl[12] = '{3'b001, 2, 0, 0};
        tbl[13] = '{3'b001, 1, 0, 0};
        tbl[14] = '{3'b101, 2, 0, 0};
        tbl[15] = '{3'b010, 0, 0, 1};

        model_reset();
        do_reset();

        // Start: state changes 2+3+1+1 edges after the raw edge, ticks every 4 cycles
        b_ss = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            if (k == 11) b_ss = 1'b0;
            step("start");
            if (k == 6) check_val("start_latency_early", int'(state_o), 0);
            if (k == 7) check_val("start_latency", int'(state_o), 1);
            if (cnt_en === 1'b1) en_pos.push_back(k);
        end
        check_val("tick_count", en_pos.size(), 4);
        for (int i = 0; i < en_pos.size() && i < 4; i++) begin
            check_val("tick_pos", en_pos[i], 11 + 4 * i);
        end

        // Pause with two prescaler counts accumulated, wait, resume
        for (int k = 0; k < 8 && m_phase != 3; k++) step("align");
        b_ss = 1'b1;
        n_tick = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 11) b_ss = 1'b0;
            step("pause");
            if (k == 7) check_val("pause_state", int'(state_o), 2);
            if (k >= 8 && cnt_en === 1'b1) n_tick++;
        end
        check_val("pause_no_tick", n_tick, 0);
        b_ss = 1'b1;
        found = 0;
        for (int k = 1; k <= 12; k++) begin
            step("resume");
            if (state_o == 2'd1) begin
                found = k;
                break;
            end
        end
        check_val("resume_latency", found, 7);
        found = 0;
        for (int k = 1; k <= 10; k++) begin
            step("resume_tick");
            if (cnt_en === 1'b1) begin
                found = k;
                break;
            end
        end
        check_val("resume_first_tick", found, 2);
        b_ss = 1'b0;
        repeat (3) step("run");
        check_val("run_before_reset", int'(state_o), 1);

        // Reset mid-RUN, then digit scan walks 0,1,2,3,0 every two cycles
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step("scan");
            check_val("scan_sel", int'(digit_sel), exp_sel[k]);
            check_val("scan_en", int'(digit_en), exp_den[k]);
        end

        // Two-cycle glitch on start/stop is filtered
        b_ss = 1'b1;
        step("glitch");
        step("glitch");
        b_ss = 1'b0;
        repeat (12) step("glitch");
        check_val("glitch_state", int'(state_o), 0);

        // Table of presses from IDLE
        for (int i = 0; i < 16; i++) begin
            clr_seen = 0;
            press_btn(tbl[i].btn, 8, 8);
            check_val($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].st);
            check_val($sformatf("tbl%0d_hold", i), int'(hold), tbl[i].hld);
            check_val($sformatf("tbl%0d_clr", i), clr_seen, tbl[i].clrs);
        end

        // Randomized pad activity against the model
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        lvl = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    hold_left[b] = int'($urandom_range(1, 12));
                end
                hold_left[b]--;
            end
            b_ss = lvl[0]; b_clr = lvl[1]; b_lap = lvl[2];
            if ($urandom_range(0, 699) == 0) do_reset();
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Run-control and display-scan sequencer for the four-digit seven-segment timer in the user project. It debounces three raw push-button pads, runs a start/pause/lap/clear state machine, and gates a prescaled count tick and a clear pulse into the timer counter. It also schedules the shared seven-segment driver across the four digits. It sits between the user `io_in` pads and the timer datapath, clocked from the Wishbone clock.

## Interface
- `TICK_DIV`, 10000: clock cycles per count tick; must be ≥ 2.
- `DEBOUNCE_CYC`, 16: consecutive stable synchronized cycles required to accept a button level change; must be ≥ 1.
- `SCAN_DIV`, 256: clock cycles each digit stays enabled; must be ≥ 1.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `btn_start_stop` in 1: raw pad, active-high, asynchronous to the clock.
- `btn_clear` in 1: raw pad, active-high.
- `btn_lap` in 1: raw pad, active-high.
- `cnt_en` out 1: one-cycle pulse; the timer increments by one.
- `cnt_clr` out 1: one-cycle pulse; the timer zeroes its count.
- `hold` out 1: the display shows the frozen lap value while the count continues.
- `digit_sel` out 2: index of the digit currently driven.
- `digit_en` out 4: one-hot, active-high digit enable, `digit_en[digit_sel]` = 1.
- `state_o` out 2: current state encoding. IDLE=0, RUN=1, PAUSE=2, LAP=3.

## Operation
- **Input conditioning.** Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer's internal counter resets whenever the synchronized level equals the accepted level.
  - When the synchronized level differs for `DEBOUNCE_CYC` consecutive cycles, the accepted level flips.
  - A rising edge of the accepted level produces a one-cycle press event. Releases produce no event.
- **State machine.** All transitions are evaluated on press events only.
  - IDLE: `start_stop` → RUN. `clear` → stay in IDLE and pulse `cnt_clr`. `lap` is ignored.
  - RUN: `start_stop` → PAUSE. `lap` → LAP. `clear` is ignored.
  - LAP: `lap` → RUN. `start_stop` → PAUSE. `clear` is ignored.
  - PAUSE: `start_stop` → RUN. `clear` → IDLE and pulse `cnt_clr`. `lap` is ignored.
- **Simultaneous events in one cycle.** Priority is `clear` (only where `clear` is legal), then `start_stop`, then `lap`. Only one transition occurs per cycle.
- **`hold`.** `hold` = 1 exactly while in LAP.
- **Prescaler.** The prescaler counts 0..`TICK_DIV`-1.
  - It increments only in RUN and LAP.
  - It holds its value in PAUSE, so a partial period is preserved.
  - It is forced to 0 in IDLE.
  - On the cycle its value is `TICK_DIV`-1 while running, it wraps to 0 and `cnt_en` pulses on the next cycle (registered).
- **Scan scheduler.** The scan counter counts 0..`SCAN_DIV`-1 in every state, including IDLE.
  - On wrap, `digit_sel` increments modulo 4 (3 wraps to 0).
  - `digit_en` is the registered one-hot decode of `digit_sel`.

## Timing
- **Reset values.** On asserting `wb_rst_i`, all outputs go to their reset values immediately:
  - state IDLE, `state_o` = 0, `cnt_en` = 0, `cnt_clr` = 0, `hold` = 0
  - `digit_sel` = 0, `digit_en` = 4'b0001
  - prescaler, scan counter and debounce counters = 0; accepted button levels = 0
- **Reset mid-operation.** Reset returns the block to IDLE with no `cnt_clr` pulse. The timer shares `wb_rst_i` and clears itself.
- **Press latency.** From a stable raw level change to the state/`hold`/`cnt_clr` update: 2 (sync) + `DEBOUNCE_CYC` (debounce) + 1 (edge) + 1 (FSM register) cycles.
- **Tick timing.** In uninterrupted RUN, `cnt_en` pulses are exactly `TICK_DIV` cycles apart. The first pulse comes `TICK_DIV` cycles after entering RUN from IDLE.
- **Glitches.** A raw glitch shorter than `DEBOUNCE_CYC` synchronized cycles produces no event.
- **Pulse widths.** `cnt_clr` and `cnt_en` are never asserted in the same cycle. Each is exactly one cycle wide.

## Configuration
- Macro: `TIMER_CTRL_LAP_EN`.
- Defined: the LAP state and `hold` behave as described above.
- Undefined:
  - `btn_lap` is left unconnected internally (no synchronizer or debouncer).
  - LAP is unreachable.
  - `hold` is tied to 0.
  - `state_o` never reads 3.
  - All other behaviour is unchanged.

## Test plan
All scenarios use `TICK_DIV`=4, `DEBOUNCE_CYC`=3, `SCAN_DIV`=2.
- **Reset.** Assert `wb_rst_i` mid-RUN → outputs immediately at reset values. After release, `digit_sel` steps 0,1,2,3,0 every 2 cycles and `digit_en` follows as 0001,0010,0100,1000.
- **Start and tick.** Press `start_stop` for 10 cycles → `state_o`=1 at 2+3+1+1 cycles after the raw edge, then `cnt_en` pulses every 4 cycles. A second press gives `state_o`=2 and `cnt_en` stops.
- **Pause preserves prescaler.** Pause with prescaler=2, wait 20 cycles, resume → the first `cnt_en` comes 2 cycles after re-entering RUN.
- **Glitch and priority.**
  - A 2-cycle `start_stop` glitch → no state change.
  - In PAUSE, `clear` and `start_stop` pressed in the same cycle → IDLE plus a single `cnt_clr` pulse.
  - In RUN, `clear` → ignored.
- **Lap** (`TIMER_CTRL_LAP_EN` defined). In RUN, press `lap` → `state_o`=3, `hold`=1, `cnt_en` continues every 4 cycles. Press `lap` again → RUN, `hold`=0.
- **Lap compiled out** (`TIMER_CTRL_LAP_EN` undefined). Press `lap` in RUN → `state_o` stays 1 and `hold` stays 0.
